tcp_tx_framer: RTL and testbench
================================

# tcp_tx_framer

Multi-channel, parametrised successor to the single-stream data path that feeds the SiTCP TCP transmit port. N_CH independent byte producers each write into their own buffer. A round-robin scheduler drains the buffers and wraps each burst in a self-describing frame. The framer drives SiTCP TCP_TX_WR/TCP_TX_DATA directly, honours TCP_TX_FULL, and flushes on TCP connection loss.

## Interface
Parameters:
- N_CH, 4 — number of producer channels (1..16)
- DEPTH_LOG2, 9 — per-channel buffer depth, 2^DEPTH_LOG2 bytes
- MAX_PAYLOAD, 256 — maximum payload bytes per frame (1..256, ≤ 2^DEPTH_LOG2)
- FLUSH_TIMEOUT, 16'd2000 — cycles a non-empty channel waits below MAX_PAYLOAD before a partial frame is forced
- MAGIC, 8'hA5 — frame start byte

Ports:
- CLK_200M  in  1  system clock
- SYS_RSTn  in  1  asynchronous, active-low reset
- TCP_OPEN_ACK  in  1  SiTCP connection up; 0 = synchronous flush
- CH_DATA  in  8*N_CH  channel c byte at [8c+7:8c]
- CH_WE  in  N_CH  per-channel write strobe
- CH_FULL  out  N_CH  buffer c full; writes while 1 are dropped
- TCP_TX_FULL  in  1  SiTCP almost-full
- TCP_TX_WR  out  1  byte strobe to SiTCP
- TCP_TX_DATA  out  8  byte to SiTCP
- DROP_CNT  out  16  dropped bytes, all channels, saturating at 16'hFFFF
- FRAME_CNT  out  16  completed frames, wrapping

## Operation
- Frame format: MAGIC, channel id (8 bits, zero-extended), L-1, payload[0..L-1], checksum. L is 1..MAX_PAYLOAD. The checksum is the XOR of the payload bytes. Frame length is L+4 bytes.
- Write path: a byte is accepted when CH_WE[c]=1 and CH_FULL[c]=0. CH_FULL is derived from the registered occupancy. A write while CH_FULL=1 is dropped and increments DROP_CNT, even if a read occurs in the same cycle.
- A channel becomes eligible when either condition holds:
  - occupancy ≥ MAX_PAYLOAD, or
  - occupancy > 0 and its timeout counter has reached FLUSH_TIMEOUT.
- Timeout counter: one per channel, 16 bits. It clears when the channel is empty or is granted, and otherwise increments, saturating.
- Arbitration happens in IDLE only. Among eligible channels, the first one at or after (last_grant+1) mod N_CH is granted. After reset, last_grant is N_CH-1. On grant, L = min(occupancy, MAX_PAYLOAD) is latched.
- FSM states: IDLE → S_MAGIC → S_CH → S_LEN → S_PAY (L bytes) → S_CK → IDLE. A state emitting a byte advances only in cycles where a byte is issued.
- Byte issue: a byte is issued in cycle n only if TCP_TX_FULL=0 at edge n. Otherwise the FSM holds and TCP_TX_WR=0. The SiTCP almost-full margin absorbs the one-cycle output register.
- Bytes written during a frame are not included in that frame. They remain buffered for the next frame.
- FRAME_CNT increments when the checksum byte is issued.
- TCP_OPEN_ACK=0: all buffers, occupancies and timeout counters clear and the FSM goes to IDLE. A frame in progress is aborted; the checksum is not sent and FRAME_CNT is not incremented. No writes are accepted while TCP_OPEN_ACK=0. DROP_CNT and FRAME_CNT are preserved.
- SYS_RSTn=0: everything clears, including both counters.

## Timing
- Reset values: TCP_TX_WR=0, TCP_TX_DATA=8'h00, CH_FULL=0, DROP_CNT=0, FRAME_CNT=0, FSM=IDLE.
- All outputs are registered.
- Latency:
  - CH_WE to occupancy visible: 1 cycle.
  - Occupancy reaching MAX_PAYLOAD to grant: 1 cycle.
  - Grant to MAGIC on TCP_TX_WR: 1 cycle.
- With TCP_TX_FULL=0 throughout, a frame occupies L+4 consecutive TCP_TX_WR cycles. Back-to-back frames are separated by exactly 1 idle (arbitration) cycle.
- Buffers are first-word-fall-through. The read strobe equals "payload byte issued", so there are no bubbles inside the payload.
- TCP_TX_FULL asserted mid-payload: the byte stream pauses with no loss and no duplication, then resumes from the next byte.
- Occupancy pointers wrap modulo 2^DEPTH_LOG2. Occupancy is DEPTH_LOG2+1 bits wide, so a completely full buffer is distinguishable from an empty one.

## Structure
- Package tcp_tx_framer_pkg holds:
  - FSM state enumeration
  - header/trailer byte count constant (4)
  - clog2 function used for channel-id and pointer widths
- Sub-module tcp_tx_chbuf: single-clock FWFT byte FIFO. It has DEPTH_LOG2 parameter, synchronous clear input, we/re strobes, count and full outputs, and infers block RAM. It is instantiated N_CH times via generate.
- The top level contains the arbiter, timeout counters, FSM, checksum register and statistics counters.

## Test plan
- N_CH=4, MAX_PAYLOAD=4: write 4 bytes 01..04 to ch2 → A5,02,03,01,02,03,04,04 with TCP_TX_WR high for 8 consecutive cycles; FRAME_CNT=1.
- Write 3 bytes to ch0 and wait FLUSH_TIMEOUT=100 → partial frame with length byte 02 issued 101–102 cycles after the last write.
- Fill ch0, ch1 and ch3 to MAX_PAYLOAD at the same time → frames issued in order 0, 1, 3; a second round after refill starts at channel 0 again (last_grant was 3).
- Hold TCP_TX_FULL=1 for 10 cycles mid-payload → no TCP_TX_WR during the hold; the complete payload and checksum are still correct.
- DEPTH_LOG2=4: write 20 bytes to ch1 with no drain → CH_FULL[1]=1 after 16 bytes, DROP_CNT=4.
- Drop TCP_OPEN_ACK during S_PAY → TCP_TX_WR=0 from the next cycle, all occupancies 0, FRAME_CNT unchanged; after re-open, a new write produces a fresh frame.

Source files
------------

// File: rtl/tcp_tx_framer_pkg.sv
// tcp_tx_framer_pkg: shared types and constants for the SiTCP TX framer.
//   state_e       - framer FSM states
//   HDR_TRL_BYTES - bytes a frame carries beyond its payload (magic, id, len, checksum)
//   clog2         - elaboration-time ceil(log2) for id / pointer widths
package tcp_tx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_MAGIC,
    S_CH,
    S_LEN,
    S_PAY,
    S_CK
  } state_e;

  localparam int HDR_TRL_BYTES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tcp_tx_chbuf.sv
// tcp_tx_chbuf: single-clock first-word-fall-through byte FIFO, 2^DEPTH_LOG2 deep.
//   CLK_200M, SYS_RSTn - clock, async active-low reset
//   clr_i              - synchronous clear of pointers and occupancy
//   we_i / din_i       - write strobe and byte (ignored while full)
//   re_i / dout_o      - read strobe; dout_o always shows the head byte
//   count_o            - occupancy, DEPTH_LOG2+1 bits so full != empty
//   full_o             - occupancy == 2^DEPTH_LOG2
module tcp_tx_chbuf #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  CLK_200M,
  input  logic                  SYS_RSTn,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [7:0]            din_i,
  input  logic                  re_i,
  output logic [7:0]            dout_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_we, do_re;

  // The MSB of the occupancy is set only when the buffer holds exactly DEPTH bytes.
  assign full_o  = count_q[DEPTH_LOG2];
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_we = we_i & ~full_o & ~clr_i;
  assign do_re = re_i & (count_q != '0) & ~clr_i;

  // Storage carries no reset so it maps onto RAM.
  always_ff @(posedge CLK_200M)
    if (do_we) mem_q[wr_ptr_q] <= din_i;

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_we) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_re) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_we, do_re})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tcp_tx_framer.sv
// tcp_tx_framer: N_CH byte producers, round-robin framed onto the SiTCP TX port.
// Frame: MAGIC, channel id, L-1, payload[L], XOR checksum of payload.
//   CLK_200M, SYS_RSTn   - clock, async active-low reset
//   TCP_OPEN_ACK         - connection up; low flushes all buffers and aborts a frame
//   CH_DATA/CH_WE        - per-channel byte and write strobe (channel c at [8c+7:8c])
//   CH_FULL              - per-channel buffer full, writes then dropped
//   TCP_TX_FULL          - SiTCP almost-full, stalls byte issue
//   TCP_TX_WR/TCP_TX_DATA- registered byte stream to SiTCP
//   DROP_CNT             - dropped writes, saturating
//   FRAME_CNT            - completed frames, wrapping
module tcp_tx_framer
  import tcp_tx_framer_pkg::*;
#(
  parameter int          N_CH          = 4,
  parameter int          DEPTH_LOG2    = 9,
  parameter int          MAX_PAYLOAD   = 256,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd2000,
  parameter logic [7:0]  MAGIC         = 8'hA5
) (
  input  logic              CLK_200M,
  input  logic              SYS_RSTn,
  input  logic              TCP_OPEN_ACK,
  input  logic [8*N_CH-1:0] CH_DATA,
  input  logic [N_CH-1:0]   CH_WE,
  output logic [N_CH-1:0]   CH_FULL,
  input  logic              TCP_TX_FULL,
  output logic              TCP_TX_WR,
  output logic [7:0]        TCP_TX_DATA,
  output logic [15:0]       DROP_CNT,
  output logic [15:0]       FRAME_CNT
);

  localparam int CH_W  = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam int OCC_W = DEPTH_LOG2 + 1;

  logic [N_CH-1:0]            buf_we, buf_re, buf_full, elig, drop_vec;
  logic [N_CH-1:0][7:0]       buf_dout;
  logic [N_CH-1:0][OCC_W-1:0] buf_cnt;
  logic [N_CH-1:0][15:0]      tmr_q;

  state_e          state_q;
  logic [CH_W-1:0] ch_q, last_q, gnt_ch;
  logic [8:0]      len_q, pay_q, gnt_len;
  logic [7:0]      ck_q, data_q;
  logic            wr_q, gnt_vld, grant, rd_en, issue;
  logic [15:0]     drop_q, frame_q;
  logic [16:0]     drop_sum;
  int              idx;

  assign issue = ~TCP_TX_FULL;
  assign rd_en = (state_q == S_PAY) & issue & TCP_OPEN_ACK;
  assign grant = (state_q == IDLE) & gnt_vld & TCP_OPEN_ACK;

  assign CH_FULL     = buf_full;
  assign TCP_TX_WR   = wr_q;
  assign TCP_TX_DATA = data_q;
  assign DROP_CNT    = drop_q;
  assign FRAME_CNT   = frame_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign buf_we[c]   = CH_WE[c] & TCP_OPEN_ACK;
    assign buf_re[c]   = rd_en & (ch_q == CH_W'(c));
    assign drop_vec[c] = CH_WE[c] & buf_full[c] & TCP_OPEN_ACK;
    assign elig[c]     = (int'(buf_cnt[c]) >= MAX_PAYLOAD) ||
                         ((buf_cnt[c] != '0) && (tmr_q[c] >= FLUSH_TIMEOUT));

    tcp_tx_chbuf #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
      .CLK_200M (CLK_200M),
      .SYS_RSTn (SYS_RSTn),
      .clr_i    (~TCP_OPEN_ACK),
      .we_i     (buf_we[c]),
      .din_i    (CH_DATA[8*c +: 8]),
      .re_i     (buf_re[c]),
      .dout_o   (buf_dout[c]),
      .count_o  (buf_cnt[c]),
      .full_o   (buf_full[c])
    );
  end

  // Rotating priority: search starts one past the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(last_q) + 1 + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && elig[CH_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_len = 9'(MAX_PAYLOAD);
    if (int'(buf_cnt[gnt_ch]) < MAX_PAYLOAD) gnt_len = 9'(buf_cnt[gnt_ch]);
  end

  assign drop_sum = {1'b0, drop_q} + 17'($countones(drop_vec));

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      tmr_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!TCP_OPEN_ACK || buf_cnt[c] == '0 || (grant && gnt_ch == CH_W'(c)))
          tmr_q[c] <= '0;
        else if (tmr_q[c] != 16'hFFFF)
          tmr_q[c] <= tmr_q[c] + 16'd1;
      end
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CH_W'(N_CH - 1);
      len_q   <= '0;
      pay_q   <= '0;
      ck_q    <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      frame_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (!TCP_OPEN_ACK) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (gnt_vld) begin
            state_q <= S_MAGIC;
            ch_q    <= gnt_ch;
            last_q  <= gnt_ch;
            len_q   <= gnt_len;
          end
          S_MAGIC: if (issue) begin
            wr_q    <= 1'b1;
            data_q  <= MAGIC;
            state_q <= S_CH;
          end
          S_CH: if (issue) begin
            wr_q    <= 1'b1;
            data_q  <= 8'(ch_q);
            state_q <= S_LEN;
          end
          S_LEN: if (issue) begin
            wr_q    <= 1'b1;
            data_q  <= 8'(len_q - 9'd1);
            pay_q   <= '0;
            ck_q    <= '0;
            state_q <= S_PAY;
          end
          // Head byte falls through; the read strobe pops it in the same cycle.
          S_PAY: if (issue) begin
            wr_q   <= 1'b1;
            data_q <= buf_dout[ch_q];
            ck_q   <= ck_q ^ buf_dout[ch_q];
            pay_q  <= pay_q + 9'd1;
            if (pay_q == len_q - 9'd1) state_q <= S_CK;
          end
          S_CK: if (issue) begin
            wr_q    <= 1'b1;
            data_q  <= ck_q;
            frame_q <= frame_q + 16'd1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_framer.sv
module tb_tcp_tx_framer;

  localparam int          N_CH = 4;
  localparam int          D    = 4;
  localparam int          MAXP = 4;
  localparam logic [15:0] FTO  = 16'd100;

  logic              CLK_200M = 1'b0;
  logic              SYS_RSTn;
  logic              TCP_OPEN_ACK;
  logic [8*N_CH-1:0] CH_DATA;
  logic [N_CH-1:0]   CH_WE;
  logic [N_CH-1:0]   CH_FULL;
  logic              TCP_TX_FULL;
  logic              TCP_TX_WR;
  logic [7:0]        TCP_TX_DATA;
  logic [15:0]       DROP_CNT;
  logic [15:0]       FRAME_CNT;

  tcp_tx_framer #(
    .N_CH(N_CH), .DEPTH_LOG2(D), .MAX_PAYLOAD(MAXP),
    .FLUSH_TIMEOUT(FTO), .MAGIC(8'hA5)
  ) dut (
    .CLK_200M(CLK_200M), .SYS_RSTn(SYS_RSTn), .TCP_OPEN_ACK(TCP_OPEN_ACK),
    .CH_DATA(CH_DATA), .CH_WE(CH_WE), .CH_FULL(CH_FULL),
    .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA),
    .DROP_CNT(DROP_CNT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK_200M = ~CLK_200M;

  typedef struct { logic [7:0] d; bit is_len; } exp_t;
  exp_t q[$];

  int   errors = 0, checks = 0;
  int   cyc = 0, run = 0, last_run = 0, len_cyc = 0, last_wr_cyc = 0;
  int   exp_frames = 0;
  logic full_s = 1'b0;

  always @(posedge CLK_200M) begin
    cyc    <= cyc + 1;
    full_s <= TCP_TX_FULL;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every TCP_TX_WR must match the head of the expected queue.
  always @(negedge CLK_200M) begin
    exp_t e;
    if (full_s && SYS_RSTn) chk("wr_while_full", {31'd0, TCP_TX_WR}, 32'd0);
    if (TCP_TX_WR) begin
      if (q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("tx_byte", {24'd0, TCP_TX_DATA}, {24'd0, e.d});
        if (e.is_len) len_cyc = cyc;
      end
      run++;
    end else if (run > 0) begin
      last_run = run;
      run      = 0;
    end
  end

  task automatic push_frame(input int ch, input int len, input logic [7:0] base);
    logic [7:0] ck;
    ck = 8'h00;
    q.push_back('{8'hA5, 1'b0});
    q.push_back('{8'(ch), 1'b0});
    q.push_back('{8'(len - 1), 1'b1});
    for (int i = 0; i < len; i++) begin
      q.push_back('{base + 8'(i), 1'b0});
      ck = ck ^ (base + 8'(i));
    end
    q.push_back('{ck, 1'b0});
    exp_frames++;
  endtask

  // Channel c receives base + stride*c + i on write i.
  task automatic wr(input int mask, input int n, input logic [7:0] base, input int stride);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK_200M);
      CH_WE = N_CH'(mask);
      for (int c = 0; c < N_CH; c++) CH_DATA[8*c +: 8] = base + 8'(stride * c) + 8'(i);
    end
    @(negedge CLK_200M);
    CH_WE       = '0;
    last_wr_cyc = cyc;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge CLK_200M); #1;
      if (q.size() == 0 && !TCP_TX_WR) break;
    end
    if (k == 3000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_q(input int left);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge CLK_200M); #1;
      if (q.size() <= left) break;
    end
    if (k == 500) chk("wait_q_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    SYS_RSTn = 1'b0; TCP_OPEN_ACK = 1'b1; CH_DATA = '0; CH_WE = '0; TCP_TX_FULL = 1'b0;
    repeat (3) @(negedge CLK_200M);
    chk("rst_wr",    {31'd0, TCP_TX_WR}, 32'd0);
    chk("rst_data",  {24'd0, TCP_TX_DATA}, 32'd0);
    chk("rst_full",  {28'd0, CH_FULL}, 32'd0);
    chk("rst_drop",  {16'd0, DROP_CNT}, 32'd0);
    chk("rst_frame", {16'd0, FRAME_CNT}, 32'd0);
    SYS_RSTn = 1'b1;
    repeat (2) @(negedge CLK_200M);

    // Round robin from reset (last_grant = 3): 0, 1, 3, then again 0, 1, 3.
    push_frame(0, 4, 8'h20); push_frame(1, 4, 8'h30); push_frame(3, 4, 8'h50);
    wr(4'b1011, 4, 8'h20, 16);
    drain();
    chk("rr1_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));
    push_frame(0, 4, 8'h80); push_frame(1, 4, 8'h90); push_frame(3, 4, 8'hB0);
    wr(4'b1011, 4, 8'h80, 16);
    drain();
    chk("rr2_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));

    // Full frame on ch2: A5 02 03 01 02 03 04 04, 8 back-to-back strobes.
    push_frame(2, 4, 8'h01);
    wr(4'b0100, 4, 8'h01, 0);
    drain();
    chk("ch2_run", 32'(last_run), 32'd8);
    chk("ch2_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));

    // Partial frame forced by timeout.
    push_frame(0, 3, 8'h10);
    wr(4'b0001, 3, 8'h10, 0);
    drain();
    chk("tmo_latency_ok", {31'd0, ((len_cyc - last_wr_cyc) >= 101) && ((len_cyc - last_wr_cyc) <= 102)}, 32'd1);
    chk("tmo_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));

    // Back-pressure for 10 cycles after the first payload byte.
    push_frame(1, 4, 8'h70);
    wr(4'b0010, 4, 8'h70, 0);
    wait_q(4);
    TCP_TX_FULL = 1'b1;
    repeat (10) @(negedge CLK_200M);
    #1 TCP_TX_FULL = 1'b0;
    drain();
    chk("hold_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));

    // Overflow ch1 while SiTCP is full: 16 stored, 4 dropped.
    TCP_TX_FULL = 1'b1;
    for (int f = 0; f < 4; f++) push_frame(1, 4, 8'h40 + 8'(4 * f));
    wr(4'b0010, 15, 8'h40, 0);
    chk("full_after15", {31'd0, CH_FULL[1]}, 32'd0);
    wr(4'b0010, 1, 8'h4F, 0);
    chk("full_after16", {31'd0, CH_FULL[1]}, 32'd1);
    wr(4'b0010, 4, 8'hE0, 0);
    chk("drop_cnt", {16'd0, DROP_CNT}, 32'd4);
    TCP_TX_FULL = 1'b0;
    drain();
    chk("ovf_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));
    chk("drop_kept", {16'd0, DROP_CNT}, 32'd4);
    chk("full_cleared", {28'd0, CH_FULL}, 32'd0);

    // Connection loss mid-payload: abort after two payload bytes.
    q.push_back('{8'hA5, 1'b0}); q.push_back('{8'h02, 1'b0}); q.push_back('{8'h03, 1'b1});
    q.push_back('{8'h51, 1'b0}); q.push_back('{8'h52, 1'b0});
    wr(4'b0100, 4, 8'h51, 0);
    wait_q(0);
    TCP_OPEN_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_200M); #1;
      chk("abort_wr", {31'd0, TCP_TX_WR}, 32'd0);
    end
    chk("abort_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));
    chk("abort_full", {28'd0, CH_FULL}, 32'd0);
    TCP_OPEN_ACK = 1'b1;
    push_frame(2, 4, 8'h61);
    wr(4'b0100, 4, 8'h61, 0);
    drain();
    chk("reopen_frames", {16'd0, FRAME_CNT}, 32'(exp_frames));
    chk("final_drop", {16'd0, DROP_CNT}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
